// File: rtl/fibonacci_stream_if.sv
// Output stream bundle for fibonacci_stream: valid/ready handshake plus packed lane data.
// The master (generator) drives out_vld/out_data; the slave (consumer) drives out_rdy.
interface fibonacci_stream_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 2
);
  logic                 out_vld;
  logic                 out_rdy;
  logic [LANES*W-1:0]   out_data;

  modport master (
    output out_vld,
    output out_data,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_data,
    output out_rdy
  );
endinterface

// File: rtl/fibonacci_stream.sv
// Fibonacci term generator emitting LANES terms per beat over a valid/ready stream.
// Define FIBONACCI_STREAM_SAT_EN to saturate each add at 2^W-1 instead of wrapping.
module fibonacci_stream #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [W-1:0]         seed0,
  input  logic [W-1:0]         seed1,
  input  logic [LEN_W-1:0]     len,
  fibonacci_stream_if.master   out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 af_q, af_d, bf_q, bf_d;
  logic [LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic                 vld_q, vld_d, ovf_q, ovf_d;
  logic [LANES*W-1:0]   data_q, data_d;

  logic [W-1:0]         term [LANES+2];
  logic                 wrap [LANES+2];
  logic [W:0]           sum;
  logic [LANES*W-1:0]   beat;
  logic                 beat_wrap;
  logic                 launch;
  logic                 xfer;

  assign launch = start && (state_q != StRun);
  assign xfer   = (state_q == StRun) && vld_q && out_if.out_rdy;

  // Adder chain: term[0..LANES-1] form the beat, term[LANES..LANES+1] seed the next one.
  // Wrap flags propagate down the chain so later terms inherit earlier overflow.
  always_comb begin
    term[0] = launch ? seed0 : a_q;
    term[1] = launch ? seed1 : b_q;
    wrap[0] = launch ? 1'b0  : af_q;
    wrap[1] = launch ? 1'b0  : bf_q;
    sum     = '0;
    for (int k = 2; k < int'(LANES) + 2; k++) begin
      sum = {1'b0, term[k-1]} + {1'b0, term[k-2]};
`ifdef FIBONACCI_STREAM_SAT_EN
      term[k] = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
      term[k] = sum[W-1:0];
`endif
      wrap[k] = sum[W] | wrap[k-1] | wrap[k-2];
    end
    beat      = '0;
    beat_wrap = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      beat[i*W +: W] = term[i];
      beat_wrap      = beat_wrap | wrap[i];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    af_d    = af_q;
    bf_d    = bf_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          len_d   = len;
          cnt_d   = '0;
          vld_d   = 1'b1;
          data_d  = beat;
          a_d     = term[LANES];
          b_d     = term[LANES+1];
          af_d    = wrap[LANES];
          bf_d    = wrap[LANES+1];
          ovf_d   = beat_wrap;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          vld_d   = 1'b0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if ((len_q != '0) && (cnt_d == len_q)) begin
            state_d = StDone;
            vld_d   = 1'b0;
          end else begin
            data_d = beat;
            a_d    = term[LANES];
            b_d    = term[LANES+1];
            af_d   = wrap[LANES];
            bf_d   = wrap[LANES+1];
            ovf_d  = ovf_q | beat_wrap;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      af_q    <= 1'b0;
      bf_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      af_q    <= af_d;
      bf_q    <= bf_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign out_if.out_vld  = vld_q;
  assign out_if.out_data = data_q;
  assign busy            = (state_q == StRun);
  assign done            = (state_q == StDone);
  assign ovf             = ovf_q;

endmodule
